// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: a ripple of DIGIT full adders processes one
// slice per cycle, LSB-first, behind a valid/ready handshake on each side.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cin_top;

  assign last = (cnt == LAST);

  // Carry into the slice's top bit is kept so the final slice yields ovf.
  always_comb begin : ripple
    logic cy;
    cy            = carry;
    slice_cin_top = carry;
    slice_sum     = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      slice_cin_top = cy;
      slice_sum[i]  = opa[i] ^ opb[i] ^ cy;
      cy            = (opa[i] & opb[i]) | (cy & (opa[i] ^ opb[i]));
    end
    slice_cout = cy;
  end

  // New slice enters at the top; after N cycles acc holds the full result.
  assign acc_nxt = (acc >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          carry <= slice_cout;
          cnt   <= cnt + CW'(1);
          acc   <= acc_nxt;
          if (last) begin
            z    <= acc_nxt;
            cout <= slice_cout;
            ovf  <= slice_cout ^ slice_cin_top;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit bit-serial and a 16-bit
// nibble-serial instance driven with directed, hand-computed vectors.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid8 = 0, in_ready8, cin8 = 0, sub8 = 0, out_valid8, out_ready8 = 0, cout8, ovf8;
  logic [7:0]  a8 = '0, b8 = '0, z8;
  logic        in_valid16 = 0, in_ready16, cin16 = 0, sub16 = 0, out_valid16, out_ready16 = 0, cout16, ovf16;
  logic [15:0] a16 = '0, b16 = '0, z16;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .z(z8), .cout(cout8), .ovf(ovf8));

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .z(z16), .cout(cout16), .ovf(ovf16));

  typedef struct {
    logic [15:0] z;
    logic        c;
    logic        o;
    int          stall;
    int          t;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int n_checks = 0;
  int n_fail = 0;
  bit busy8 = 0, busy16 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input bit wide, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic ts, input logic [15:0] ez,
                       input logic ec, input logic eo, input int stall, input bit push);
    int unsigned w = 0;
    @(negedge clk);
    while (!(wide ? in_ready16 : in_ready8) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!(wide ? in_ready16 : in_ready8)) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    if (wide) begin
      a16 = ta; b16 = tb_; cin16 = tc; sub16 = ts; in_valid16 = 1'b1;
    end else begin
      a8 = ta[7:0]; b8 = tb_[7:0]; cin8 = tc; sub8 = ts; in_valid8 = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    in_valid16 = 1'b0;
    // Operands are scrambled while busy; the result must not depend on them.
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
    if (push) begin
      if (wide) q16.push_back('{z: ez, c: ec, o: eo, stall: stall, t: cyc});
      else      q8.push_back('{z: ez, c: ec, o: eo, stall: stall, t: cyc});
    end
  endtask

  initial begin : mon8
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid8) begin
        busy8 = 1;
        if (q8.size() == 0) begin
          chk("unexpected_out8", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("latency8", cyc - e.t, 8);
          chk("z8", z8, e.z[7:0]);
          chk("cout8", cout8, e.c);
          chk("ovf8", ovf8, e.o);
          repeat (e.stall) begin
            @(negedge clk);
            chk("stall_valid8", out_valid8, 1);
            chk("stall_ready8", in_ready8, 0);
            chk("stall_z8", {z8, cout8, ovf8}, {e.z[7:0], e.c, e.o});
          end
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        chk("idle_ready8", in_ready8, 1);
        chk("idle_valid8", out_valid8, 0);
        chk("hold_z8", z8, e.z[7:0]);
        busy8 = 0;
      end
    end
  end

  initial begin : mon16
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid16) begin
        busy16 = 1;
        if (q16.size() == 0) begin
          chk("unexpected_out16", 1, 0);
        end else begin
          e = q16.pop_front();
          chk("latency16", cyc - e.t, 4);
          chk("z16", z16, e.z);
          chk("cout16", cout16, e.c);
          chk("ovf16", ovf16, e.o);
          repeat (e.stall) begin
            @(negedge clk);
            chk("stall_valid16", out_valid16, 1);
            chk("stall_ready16", in_ready16, 0);
            chk("stall_z16", {z16, cout16, ovf16}, {e.z, e.c, e.o});
          end
        end
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        chk("idle_ready16", in_ready16, 1);
        chk("idle_valid16", out_valid16, 0);
        busy16 = 0;
      end
    end
  end

  initial begin : stim
    bit drained;
    #12;
    chk("rst_ready8", in_ready8, 1);
    chk("rst_valid8", out_valid8, 0);
    chk("rst_z8", {z8, cout8, ovf8}, 0);
    chk("rst_ready16", in_ready16, 1);
    chk("rst_valid16", out_valid16, 0);
    chk("rst_z16", {z16, cout16, ovf16}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    //    wide a        b        cin   sub   z        cout  ovf   stall push
    issue(0, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, 0, 1);
    issue(0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 0, 1);
    issue(0, 16'h05, 16'h07, 1'b0, 1'b1, 16'hFE, 1'b0, 1'b0, 0, 1);
    issue(0, 16'h05, 16'h07, 1'b1, 1'b1, 16'hFD, 1'b0, 1'b0, 0, 1);
    issue(0, 16'h3C, 16'h45, 1'b1, 1'b0, 16'h82, 1'b0, 1'b1, 5, 1);
    issue(0, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1, 2, 1);

    // Abort an operation in its third RUN cycle; nothing may come out.
    issue(0, 16'h12, 16'h34, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_valid8", out_valid8, 0);
    chk("midrun_ready8", in_ready8, 1);
    chk("midrun_z8", {z8, cout8, ovf8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 16'h12, 16'h34, 1'b0, 1'b0, 16'h46, 1'b0, 1'b0, 0, 1);

    issue(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 0, 1);
    issue(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 3, 1);
    issue(1, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0, 1);
    issue(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1);

    drained = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q8.size() == 0 && q16.size() == 0 && !busy8 && !busy16 && in_ready8 && in_ready16) begin
        drained = 1;
        break;
      end
    end
    chk("drain", drained, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; SHALL be >= 1 and divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, or borrow-in when sub=1.
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 out_valid  output  1  z, cout and ovf hold a completed result.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 z  output  WIDTH  sum or difference.
REQ-014 cout  output  1  final carry-out. In subtract mode, 0 means a borrow occurred.
REQ-015 ovf  output  1  two's-complement overflow flag.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RUN and DONE, with N = WIDTH/DIGIT.
REQ-017 IDLE: in_ready=1 and out_valid=0.
REQ-018 IDLE transition: on the edge where in_valid=1, the block SHALL capture a, b XOR {WIDTH{sub}} and cin XOR sub, clear the digit counter, and enter RUN.
REQ-019 RUN: in_ready=0 and out_valid=0.
REQ-020 RUN operation: each cycle the block SHALL add one DIGIT-bit slice, LSB-first, using a ripple of DIGIT full-adder cells, and register the slice carry for the next cycle.
REQ-021 RUN exit: after exactly N RUN cycles the block SHALL enter DONE, so out_valid rises N cycles after the accepting edge.
REQ-022 DONE: out_valid=1 and in_ready=0.
REQ-023 DONE stability: z, cout and ovf SHALL remain stable while out_ready=0, with no limit on stall length.
REQ-024 DONE exit: on the edge where out_ready=1, the block SHALL return to IDLE. Accepting a new operand set is not allowed in the same cycle.
REQ-025 While in RUN or DONE, the block SHALL ignore in_valid and all operand inputs. Operands changing during RUN SHALL NOT affect the result.
REQ-026 Arithmetic: z SHALL equal (a + b' + cin') mod 2^WIDTH, where b' and cin' are the inverted forms when sub=1.
- sub=1, cin=0 gives a-b.
- sub=1, cin=1 gives a-b-1.
REQ-027 cout SHALL equal the carry out of bit WIDTH-1.
REQ-028 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-029 Throughput SHALL be one operation per N+2 cycles minimum: accept, N RUN cycles, then one DONE handshake cycle.
REQ-030 When DIGIT = WIDTH (N=1), RUN SHALL last exactly one cycle.
REQ-031 z, cout and ovf SHALL hold their last result in IDLE until the next result is written.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, in_ready=1, out_valid=0, z=0, cout=0, ovf=0, and the digit counter and internal carry cleared.
REQ-033 A reset asserted mid-RUN or in DONE SHALL discard the operation with no partial output.
REQ-034 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-035 WIDTH=8, DIGIT=1, add: a=0x7F, b=0x01, cin=0 -> out_valid 8 cycles after accept, z=0x80, cout=0, ovf=1.
REQ-036 WIDTH=8, DIGIT=1, add: a=0xFF, b=0x01, cin=0 -> z=0x00, cout=1, ovf=0.
REQ-037 WIDTH=8, DIGIT=1, sub: a=0x05, b=0x07, cin=0 -> z=0xFE, cout=0, ovf=0. Same operands with cin=1 -> z=0xFD.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, z/cout/ovf unchanged, in_ready=0 throughout. Then out_ready=1 for one cycle -> IDLE next cycle with in_ready=1.
REQ-039 Reset mid-RUN: rst_n=0 at RUN cycle 3 -> out_valid=0, z=0 and in_ready=1 immediately. A new operand set is then accepted normally and completes correctly.
REQ-040 WIDTH=16, DIGIT=4: a=0x8000, b=0x8000, cin=1 -> out_valid 4 cycles after accept, z=0x0001, cout=1, ovf=1.
